// File: rtl/axi4_lite_rr_arbiter_if.sv
// rtl/axi4_lite_rr_arbiter_if.sv - N-master / 1-slave AXI4-lite bundle for axi4_lite_rr_arbiter
// slave modport: arbiter view; master modport: environment (masters + slave memory) view.
interface axi4_lite_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;

  logic [N-1:0]                  prerequest;
  logic [N-1:0]                  grant;

  logic [N-1:0][ADDR_WIDTH-1:0]  maraddr;
  logic [N-1:0]                  marvalid;
  logic [N-1:0]                  marready;
  logic [N-1:0][DATA_WIDTH-1:0]  mrdata;
  logic [N-1:0][1:0]             mrresp;
  logic [N-1:0]                  mrvalid;
  logic [N-1:0]                  mrready;
  logic [N-1:0][ADDR_WIDTH-1:0]  mawaddr;
  logic [N-1:0]                  mawvalid;
  logic [N-1:0]                  mawready;
  logic [N-1:0][DATA_WIDTH-1:0]  mwdata;
  logic [N-1:0][SW-1:0]          mwstrb;
  logic [N-1:0]                  mwvalid;
  logic [N-1:0]                  mwready;
  logic [N-1:0][1:0]             mbresp;
  logic [N-1:0]                  mbvalid;
  logic [N-1:0]                  mbready;

  logic [ADDR_WIDTH-1:0]         saraddr;
  logic                          sarvalid;
  logic                          sarready;
  logic [DATA_WIDTH-1:0]         srdata;
  logic [1:0]                    srresp;
  logic                          srvalid;
  logic                          srready;
  logic [ADDR_WIDTH-1:0]         sawaddr;
  logic                          sawvalid;
  logic                          sawready;
  logic [DATA_WIDTH-1:0]         swdata;
  logic [SW-1:0]                 swstrb;
  logic                          swvalid;
  logic                          swready;
  logic [1:0]                    sbresp;
  logic                          sbvalid;
  logic                          sbready;

  modport slave (
    input  prerequest, output grant,
    input  maraddr, marvalid, output marready,
    output mrdata, mrresp, mrvalid, input mrready,
    input  mawaddr, mawvalid, output mawready,
    input  mwdata, mwstrb, mwvalid, output mwready,
    output mbresp, mbvalid, input mbready,
    output saraddr, sarvalid, input sarready,
    input  srdata, srresp, srvalid, output srready,
    output sawaddr, sawvalid, input sawready,
    output swdata, swstrb, swvalid, input swready,
    input  sbresp, sbvalid, output sbready
  );

  modport master (
    output prerequest, input grant,
    output maraddr, marvalid, input marready,
    input  mrdata, mrresp, mrvalid, output mrready,
    output mawaddr, mawvalid, input mawready,
    output mwdata, mwstrb, mwvalid, input mwready,
    input  mbresp, mbvalid, output mbready,
    input  saraddr, sarvalid, output sarready,
    output srdata, srresp, srvalid, input srready,
    input  sawaddr, sawvalid, output sawready,
    input  swdata, swstrb, swvalid, output swready,
    output sbresp, sbvalid, input sbready
  );
endinterface

// File: rtl/axi4_lite_rr_arbiter.sv
// rtl/axi4_lite_rr_arbiter.sv - N-master to 1-slave AXI4-lite arbiter, one transaction in flight
// AXI_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed priority (highest index wins).
module axi4_lite_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_lite_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [ADDR_WIDTH-1:0]   ADDR_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = '0;
  localparam logic [DATA_WIDTH/8-1:0] STRB_ZERO = '0;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_AR, S_R, S_AWW, S_B} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IW-1:0]          r_g;
  logic [IW-1:0]          w_win;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [NUM_MASTERS-1:0] w_req;
  logic                   r_aw_done;
  logic                   r_w_done;
  logic                   w_aw_hs;
  logic                   w_w_hs;

  assign w_req     = bus.marvalid | bus.mawvalid | bus.prerequest;
  assign bus.grant = r_grant;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_p;
  logic [IW-1:0] w_rr_idx;

  // Scan from the far end back to p so the nearest requester at/after p is the last write.
  always_comb begin
    w_win    = '0;
    w_rr_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_rr_idx = IW'((int'(r_p) + k) % NUM_MASTERS);
      if (w_req[w_rr_idx]) w_win = w_rr_idx;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_req[i]) w_win = IW'(i);
    end
  end
`endif

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    bus.marready = '0;
    bus.mrdata   = '0;
    bus.mrresp   = '0;
    bus.mrvalid  = '0;
    bus.mawready = '0;
    bus.mwready  = '0;
    bus.mbresp   = '0;
    bus.mbvalid  = '0;
    bus.saraddr  = ADDR_ZERO;
    bus.sarvalid = 1'b0;
    bus.srready  = 1'b0;
    bus.sawaddr  = ADDR_ZERO;
    bus.sawvalid = 1'b0;
    bus.swdata   = DATA_ZERO;
    bus.swstrb   = STRB_ZERO;
    bus.swvalid  = 1'b0;
    bus.sbready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          if (bus.marvalid[w_win])      w_state_nxt = S_AR;
          else if (bus.mawvalid[w_win]) w_state_nxt = S_AWW;
          else                          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.marvalid[r_g])         w_state_nxt = S_AR;
        else if (bus.mawvalid[r_g])    w_state_nxt = S_AWW;
        else if (!bus.prerequest[r_g]) w_state_nxt = S_IDLE;
      end
      S_AR: begin
        bus.sarvalid      = bus.marvalid[r_g];
        bus.saraddr       = bus.maraddr[r_g];
        bus.marready[r_g] = bus.sarready;
        if (bus.marvalid[r_g] && bus.sarready) w_state_nxt = S_R;
      end
      S_R: begin
        bus.mrvalid[r_g] = bus.srvalid;
        bus.mrdata[r_g]  = bus.srdata;
        bus.mrresp[r_g]  = bus.srresp;
        bus.srready      = bus.mrready[r_g];
        if (bus.srvalid && bus.mrready[r_g]) w_state_nxt = S_IDLE;
      end
      S_AWW: begin
        // Each channel is masked once its handshake is recorded so it is never re-issued.
        w_aw_hs           = bus.mawvalid[r_g] && bus.sawready && !r_aw_done;
        w_w_hs            = bus.mwvalid[r_g] && bus.swready && !r_w_done;
        bus.sawvalid      = bus.mawvalid[r_g] && !r_aw_done;
        bus.sawaddr       = bus.mawaddr[r_g];
        bus.mawready[r_g] = bus.sawready && !r_aw_done;
        bus.swvalid       = bus.mwvalid[r_g] && !r_w_done;
        bus.swdata        = bus.mwdata[r_g];
        bus.swstrb        = bus.mwstrb[r_g];
        bus.mwready[r_g]  = bus.swready && !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_B;
      end
      S_B: begin
        bus.mbvalid[r_g] = bus.sbvalid;
        bus.mbresp[r_g]  = bus.sbresp;
        bus.sbready      = bus.mbready[r_g];
        if (bus.sbvalid && bus.mbready[r_g]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_g       <= '0;
      r_grant   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && |w_req) begin
        r_g     <= w_win;
        r_grant <= w_win_oh;
      end else if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
        r_grant <= '0;
      end
      if (r_state == S_AWW) begin
        if (w_state_nxt == S_B) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
      end
    end
  end

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // Rotate only after a completed transaction; abandoning HOLD keeps the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if ((r_state == S_R || r_state == S_B) && w_state_nxt == S_IDLE) begin
      r_p <= (r_g == IW'(NUM_MASTERS - 1)) ? '0 : r_g + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// tb/tb_axi4_lite_rr_arbiter.sv - scoreboard bench for axi4_lite_rr_arbiter (N=4)
module tb_axi4_lite_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] MAGIC = 32'h5EAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          m;
    bit          is_wr;
    logic [33:0] data;
  } exp_t;
  exp_t sb[$];

  bit          m_rd_act [N];
  logic [31:0] m_rd_addr[N];
  bit          m_wr_act [N];
  bit          m_aw_sent[N];
  bit          m_w_sent [N];
  logic [31:0] m_wr_addr[N];
  logic [31:0] m_wr_data[N];
  bit          m_pre    [N];

  bit sl_arready, sl_awready, sl_wready, sl_rvalid_en;
  bit sl_rpend, sl_aw_got, sl_w_got, sl_bpend;
  logic [31:0] sl_rdata, sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;

  task automatic expect_rd(input int mi, input logic [31:0] addr);
    sb.push_back('{m: mi, is_wr: 1'b0, data: {2'b00, addr ^ MAGIC}});
  endtask

  task automatic expect_wr(input int mi);
    sb.push_back('{m: mi, is_wr: 1'b1, data: 34'h0});
  endtask

  task automatic rd(input int i, input logic [31:0] addr);
    m_rd_act[i]  = 1'b1;
    m_rd_addr[i] = addr;
  endtask

  task automatic wr(input int i, input logic [31:0] addr, input logic [31:0] data);
    m_wr_act[i]  = 1'b1;
    m_aw_sent[i] = 1'b0;
    m_w_sent[i]  = 1'b0;
    m_wr_addr[i] = addr;
    m_wr_data[i] = data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_rd_act[i] = 0; m_rd_addr[i] = '0; m_wr_act[i] = 0; m_aw_sent[i] = 0;
      m_w_sent[i] = 0; m_wr_addr[i] = '0; m_wr_data[i] = '0; m_pre[i] = 0;
    end
    sl_arready = 1; sl_awready = 1; sl_wready = 1; sl_rvalid_en = 1;
    sl_rpend = 0; sl_aw_got = 0; sl_w_got = 0; sl_bpend = 0;
    sl_rdata = '0; sl_awaddr = '0; sl_wdata = '0; sl_wstrb = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.prerequest[i] = m_pre[i];
      bus.marvalid[i]   = m_rd_act[i];
      bus.maraddr[i]    = m_rd_addr[i];
      bus.mrready[i]    = 1'b1;
      bus.mawvalid[i]   = m_wr_act[i] & ~m_aw_sent[i];
      bus.mawaddr[i]    = m_wr_addr[i];
      bus.mwvalid[i]    = m_wr_act[i] & ~m_w_sent[i];
      bus.mwdata[i]     = m_wr_data[i];
      bus.mwstrb[i]     = 4'b1010;
      bus.mbready[i]    = 1'b1;
    end
    bus.sarready = sl_arready;
    bus.srvalid  = sl_rpend & sl_rvalid_en;
    bus.srdata   = sl_rpend ? sl_rdata : 32'h0;
    bus.srresp   = 2'b00;
    bus.sawready = sl_awready;
    bus.swready  = sl_wready;
    bus.sbvalid  = sl_bpend;
    bus.sbresp   = 2'b00;
  endtask

  task automatic pop_check(input int i, input bit is_wr, input logic [33:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_rsp_master", i, 99);
    end else begin
      e = sb.pop_front();
      chk("rsp_master", i, e.m);
      chk("rsp_kind", is_wr, e.is_wr);
      chk("rsp_data", got, e.data);
    end
  endtask

  // Handshakes evaluated here are the ones the upcoming rising edge will complete.
  task automatic eval();
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    ar_hs = bus.sarvalid & bus.sarready;
    r_hs  = bus.srvalid & bus.srready;
    aw_hs = bus.sawvalid & bus.sawready;
    w_hs  = bus.swvalid & bus.swready;
    b_hs  = bus.sbvalid & bus.sbready;
    chk("iso", {bus.mrvalid & ~bus.grant, bus.mbvalid & ~bus.grant, bus.marready & ~bus.grant}, 0);
    for (int i = 0; i < N; i++) begin
      if (bus.marvalid[i] & bus.marready[i]) m_rd_act[i] = 0;
      if (bus.mawvalid[i] & bus.mawready[i]) m_aw_sent[i] = 1;
      if (bus.mwvalid[i] & bus.mwready[i])   m_w_sent[i] = 1;
      if (bus.mrvalid[i] & bus.mrready[i]) pop_check(i, 1'b0, {bus.mrresp[i], bus.mrdata[i]});
      if (bus.mbvalid[i] & bus.mbready[i]) begin
        pop_check(i, 1'b1, {32'h0, bus.mbresp[i]});
        m_wr_act[i] = 0; m_aw_sent[i] = 0; m_w_sent[i] = 0;
      end
    end
    if (r_hs) sl_rpend = 0;
    if (ar_hs) begin sl_rpend = 1; sl_rdata = bus.saraddr ^ MAGIC; end
    if (b_hs) sl_bpend = 0;
    if (aw_hs) begin sl_aw_got = 1; sl_awaddr = bus.sawaddr; end
    if (w_hs) begin sl_w_got = 1; sl_wdata = bus.swdata; sl_wstrb = bus.swstrb; end
    if (sl_aw_got && sl_w_got) begin sl_bpend = 1; sl_aw_got = 0; sl_w_got = 0; end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    eval();
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    sb.delete();
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    drive();
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_sarvalid", bus.sarvalid, 0);
    chk("rst_sawvalid", bus.sawvalid, 0);
    chk("rst_mrvalid", bus.mrvalid, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Single read, minimum latency and grant sequence.
    rd(0, 32'h8000_0000);
    expect_rd(0, 32'h8000_0000);
    cycle(); chk("t1_grant_idle", bus.grant, 4'b0000);
    cycle(); chk("t1_grant_ar", bus.grant, 4'b0001);
    chk("t1_sarvalid", bus.sarvalid, 1);
    chk("t1_saraddr", bus.saraddr, 32'h8000_0000);
    cycle(); chk("t1_grant_r", bus.grant, 4'b0001);
    chk("t1_mrdata0", bus.mrdata[0], 32'hDEAD_BEEF);
    chk("t1_mrvalid1", bus.mrvalid[1], 0);
    cycle(); chk("t1_grant_done", bus.grant, 4'b0000);
    chk("t1_sb_empty", sb.size(), 0);

    // Simultaneous reads from 1 and 3, then from 0 and 3.
    do_reset();
    rd(1, 32'h0000_1100); rd(3, 32'h0000_3300);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    expect_rd(1, 32'h0000_1100); expect_rd(3, 32'h0000_3300);
`else
    expect_rd(3, 32'h0000_3300); expect_rd(1, 32'h0000_1100);
`endif
    run_until_empty(40, "t2a");
    rd(0, 32'h0000_0044); rd(3, 32'h0000_3344);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    expect_rd(0, 32'h0000_0044); expect_rd(3, 32'h0000_3344);
`else
    expect_rd(3, 32'h0000_3344); expect_rd(0, 32'h0000_0044);
`endif
    run_until_empty(40, "t2b");

    // Write with W accepted two cycles ahead of AW.
    sl_awready = 0;
    wr(2, 32'h1000_0040, 32'hCAFE_F00D);
    expect_wr(2);
    cycle();
    cycle(); chk("t3_swvalid_first", bus.swvalid, 1);
    chk("t3_sawvalid_first", bus.sawvalid, 1);
    cycle(); chk("t3_swvalid_gated", bus.swvalid, 0);
    chk("t3_mwready_gated", bus.mwready[2], 0);
    chk("t3_sawvalid_wait", bus.sawvalid, 1);
    chk("t3_no_b_early", bus.mbvalid, 0);
    cycle(); chk("t3_sawvalid_wait2", bus.sawvalid, 1);
    sl_awready = 1;
    run_until_empty(10, "t3");
    chk("t3_awaddr", sl_awaddr, 32'h1000_0040);
    chk("t3_wdata", sl_wdata, 32'hCAFE_F00D);
    chk("t3_wstrb", sl_wstrb, 4'b1010);
    wr(1, 32'h2000_0000, 32'h1234_5678);
    expect_wr(1);
    run_until_empty(10, "t3b");
    chk("t3b_wdata", sl_wdata, 32'h1234_5678);

    // Prerequest holds the bus, then is released without a transaction.
    do_reset();
    m_pre[1] = 1;
    cycle(); chk("t4_grant_idle", bus.grant, 4'b0000);
    rd(0, 32'h0000_0A00);
    cycle(); chk("t4_grant_hold", bus.grant, 4'b0010);
    cycle(); chk("t4_grant_hold2", bus.grant, 4'b0010);
    chk("t4_marready0", bus.marready[0], 0);
    chk("t4_sarvalid", bus.sarvalid, 0);
    m_pre[1] = 0;
    rd(1, 32'h0000_1A00);
    expect_rd(1, 32'h0000_1A00); expect_rd(0, 32'h0000_0A00);
    run_until_empty(30, "t4a");
    m_pre[1] = 1;
    cycle();
    cycle(); chk("t4b_grant_hold", bus.grant, 4'b0010);
    m_pre[1] = 0;
    cycle(); chk("t4b_grant_drop", bus.grant, 4'b0010);
    cycle(); chk("t4b_grant_idle", bus.grant, 4'b0000);
    rd(0, 32'h0000_0B00); rd(1, 32'h0000_1B00);
    expect_rd(1, 32'h0000_1B00); expect_rd(0, 32'h0000_0B00);
    run_until_empty(30, "t4b");

    // Reset while waiting for read data.
    do_reset();
    rd(0, 32'h0000_0C00);
    expect_rd(0, 32'h0000_0C00);
    run_until_empty(10, "t5a");
    sl_rvalid_en = 0;
    rd(1, 32'h0000_1C00);
    cycle(); cycle(); cycle();
    chk("t5_grant_r", bus.grant, 4'b0010);
    chk("t5_srready_r", bus.srready, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_grant", bus.grant, 0);
    chk("t5_rst_srready", bus.srready, 0);
    chk("t5_rst_valids", {bus.sarvalid, bus.sawvalid, bus.swvalid, bus.mrvalid, bus.mbvalid}, 0);
    clear_model();
    cycle();
    rst = 1'b0;
    rd(0, 32'h0000_0D00); rd(1, 32'h0000_1D00);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    expect_rd(0, 32'h0000_0D00); expect_rd(1, 32'h0000_1D00);
`else
    expect_rd(1, 32'h0000_1D00); expect_rd(0, 32'h0000_0D00);
`endif
    cycle();
    cycle();
`ifdef AXI_ARB_ROUND_ROBIN_EN
    chk("t5_post_grant", bus.grant, 4'b0001);
`else
    chk("t5_post_grant", bus.grant, 4'b0010);
`endif
    run_until_empty(30, "t5b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
